// File: rtl/addsub_pkg.sv
// Shared definitions for the adder/subtractor datapaths: FSM states and default width.
package addsub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor cell built from gate primitives.
module fullsubtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    wire axb, na, nx, t1, t2;

    xor g_x1 (axb, A, B);
    xor g_x2 (Diff, axb, Bin);
    not g_n1 (na, A);
    and g_a1 (t1, na, B);
    not g_n2 (nx, axb);
    and g_a2 (t2, nx, Bin);
    or  g_o1 (Bout, t1, t2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first a - b using a single full-subtractor cell and a borrow flop.
module serial_subtractor
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;

    logic             cell_diff, cell_bout;
    logic [WIDTH-1:0] res_shift;

    fullsubtractor u_fs (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Bin  (borrow_q),
        .Diff (cell_diff),
        .Bout (cell_bout)
    );

    // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    assign res_shift = {cell_diff, res_q[WIDTH-1:1]};

    // Next-state logic: operand load on accept, one bit per RUN cycle, results latched on the last bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_d    = res_shift;
                borrow_d = cell_bout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = res_shift;
                    bout_d  = cell_bout;
                    zero_d  = (res_shift == '0);
                    // Overflow only possible when operand signs differ; uses captured MSBs.
                    ovf_d   = (a_msb_q ^ b_msb_q) & (cell_diff ^ a_msb_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign zero       = zero_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a result scoreboard.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, borrow_out, zero, ovf;
    logic [W-1:0] diff;

    typedef struct {
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .zero       (zero),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.diff = x - y;
        e.bout = (x < y);
        e.zero = (e.diff == '0);
        e.ovf  = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_diff"}, 32'(diff), 32'(e.diff));
            chk({tag, "_bout"}, 32'(borrow_out), 32'(e.bout));
            chk({tag, "_zero"}, 32'(zero), 32'(e.zero));
            chk({tag, "_ovf"},  32'(ovf), 32'(e.ovf));
        end
    endtask

    // Drive a request for one cycle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        if (push) sb.push_back(model(x, y));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for done counting busy cycles; optionally pulse a stray start at run cycle pulse_at.
    task automatic wait_result(input string tag, input int pulse_at, input logic [W-1:0] held);
        int busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) break;
            if (busy) busy_n++;
            if (c == 4) chk({tag, "_hold"}, 32'(diff), 32'(held));
            if (c == pulse_at) begin
                a = 8'hAA; b = 8'h55; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
        check_result(tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] xs[3];
        logic [W-1:0] ys[3];
        int           gap;
        int           ndone;

        rst_n = 1'b0; start = 1'b1; a = 8'h12; b = 8'h34;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(borrow_out), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_ovf",  32'(ovf), 32'd0);
        rst_n = 1'b1; start = 1'b0;

        issue(8'h35, 8'h12, 1'b1);
        chk("basic_busy_rise", 32'(busy), 32'd1);
        wait_result("basic", -1, 8'h00);
        issue(8'h00, 8'h01, 1'b1); wait_result("borrow", -1, 8'h23);
        issue(8'h80, 8'h01, 1'b1); wait_result("posovf", -1, 8'hFF);
        issue(8'h5A, 8'h5A, 1'b1); wait_result("zero",   -1, 8'h7F);
        issue(8'h7F, 8'hFF, 1'b1); wait_result("negovf", -1, 8'h00);

        // Stray start during RUN must be ignored.
        issue(8'h10, 8'h01, 1'b1);
        wait_result("busy_start", 2, 8'h80);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("busy_start_single", 32'(ndone), 32'd0);

        // Back-to-back with start held high.
        xs = '{8'h44, 8'h01, 8'hC0};
        ys = '{8'h11, 8'h02, 8'h40};
        @(negedge clk);
        a = xs[0]; b = ys[0]; start = 1'b1;
        sb.push_back(model(xs[0], ys[0]));
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            @(negedge clk);
            gap++;
            while (!done && gap < 40) begin
                @(negedge clk);
                gap++;
            end
            chk("b2b_done", 32'(done), 32'd1);
            if (k > 0) chk("b2b_period", 32'(gap), 32'(W + 1));
            check_result("b2b");
            if (k < 2) begin
                a = xs[k+1]; b = ys[k+1];
                sb.push_back(model(xs[k+1], ys[k+1]));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_idle", 32'(busy | done), 32'd0);

        // Reset in the middle of a run.
        issue(8'h77, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_bout", 32'(borrow_out), 32'd0);
        chk("mid_rst_zero", 32'(zero), 32'd1);
        chk("mid_rst_ovf",  32'(ovf), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid_rst_no_done", 32'(ndone), 32'd0);
        issue(8'h03, 8'h01, 1'b1);
        wait_result("after_rst", -1, 8'h00);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first two's-complement subtractor computing `a - b` over `WIDTH` clock cycles using one full-subtractor cell and a borrow flip-flop. It is the subtract-direction counterpart of the adder datapath in the Adder Subtractor project. It trades latency for area, and exposes a start/busy/done handshake so a controller can sequence operations.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  request to begin; accepted only when `busy` = 0.
- `a`  in  WIDTH  minuend; sampled on the accepting edge only.
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge only.
- `busy`  out  1  high while a subtraction is in progress (RUN state).
- `done`  out  1  one-cycle pulse when results become valid.
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow_out`  out  1  unsigned borrow; 1 iff `a < b` unsigned.
- `zero`  out  1  1 iff `diff` = 0.
- `ovf`  out  1  signed overflow: `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.

## Operation
- FSM states:
  - IDLE: `busy` = 0.
  - RUN: `busy` = 1.
  - DONE: `busy` = 0, `done` = 1.
- IDLE or DONE with `start` = 1:
  - load shift registers with `a` and `b`;
  - clear the borrow flip-flop;
  - clear the bit counter;
  - go to RUN.
- DONE with `start` = 0: go to IDLE.
- Start is therefore accepted back-to-back from DONE.
- RUN, each cycle:
  - The cell takes the current LSBs of both shift registers plus the borrow flip-flop.
  - The cell's difference bit shifts into the MSB of the result shift register.
  - The cell's borrow is registered.
  - Both operand registers shift right by one.
  - The counter increments.
- RUN with counter = WIDTH-1, after that bit is processed:
  - go to DONE;
  - update `diff`, `borrow_out`, `zero` and `ovf` on this same edge.
- `start` in RUN is ignored; no queuing, and the operands are not resampled.
- Output registers hold their last values until the next operation completes. They do not change while a new operation runs.
- `ovf` uses the captured MSBs of `a` and `b` (held in dedicated flops), not the shifted registers.
- Borrow-in at bit 0 is always 0.

## Timing
- Edge 0 (accepting edge) through completion:
  - Edge 0: `start` sampled and `busy` rises.
  - Edges 1..WIDTH: bits 0..WIDTH-1 are processed.
  - The RUN → DONE transition happens on edge WIDTH.
- `done` is high for exactly one cycle, between edge WIDTH and edge WIDTH+1. Results are valid in that cycle and remain stable afterward.
- Latency from start acceptance to `done` is WIDTH cycles; `busy` is high for exactly WIDTH cycles.
- Throughput: one result per WIDTH+1 cycles when `start` is held high continuously.
- Reset, on any edge with `rst_n` = 0, regardless of state, including mid-RUN:
  - state goes to IDLE;
  - `busy` = 0, `done` = 0;
  - `diff` = 0, `borrow_out` = 0, `ovf` = 0, `zero` = 1;
  - counter, borrow flip-flop and shift registers are cleared.
- `start` asserted in the same cycle as `rst_n` = 0 is ignored.

## Structure
- Shared package `addsub_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the default width constant.
- Counter width is `$clog2(WIDTH)`, computed locally.
- One sub-module: `fullsubtractor`.
  - Ports: inputs `A`, `B`, `Bin`; outputs `Diff`, `Bout`.
  - `Diff = A ^ B ^ Bin`.
  - `Bout = (~A & B) | (~(A ^ B) & Bin)`.
  - Built from gate primitives, matching the project's adder cells.
- The top level instantiates exactly one `fullsubtractor`.

## Test plan
- Basic subtract, WIDTH=8, `a`=0x35, `b`=0x12 → `diff`=0x23, `borrow_out`=0, `zero`=0, `ovf`=0. `done` pulses exactly 8 cycles after acceptance; `busy` is high for exactly 8 cycles.
- Unsigned borrow: `a`=0x00, `b`=0x01 → `diff`=0xFF, `borrow_out`=1, `ovf`=0. Also `a`=0x80, `b`=0x01 → `diff`=0x7F, `ovf`=1, `borrow_out`=0.
- Zero and negative overflow: `a`=0x5A, `b`=0x5A → `diff`=0x00, `zero`=1. Also `a`=0x7F, `b`=0xFF → `diff`=0x80, `ovf`=1, `borrow_out`=1.
- Start while busy: start 0x10−0x01, then pulse `start` with `a`=0xAA, `b`=0x55 at RUN cycle 3 → second request ignored; result 0x0F; one `done` pulse only.
- Back-to-back: hold `start`=1 with new operands presented each DONE cycle → `done` pulses every 9 cycles; each result matches its own operands.
- Reset mid-RUN: assert `rst_n`=0 at RUN cycle 4 → next cycle shows all outputs at reset values (`zero`=1) and no `done`. A following start of 0x03−0x01 yields `diff`=0x02.
